// File: rtl/mac_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_bist_pkg
// Brief    : Shared types and helpers for the on-chip MAC self-test driver:
//            FSM state encoding, LFSR polynomial and next-state function.
// Revision : 1.0 - initial release
// ============================================================================
package mac_bist_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        SETTLE   = 3'd2,
        RUN      = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    function automatic logic [31:0] lfsr_fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : mac_bist_lfsr
// Brief    : 32-bit Galois LFSR operand source. Load restarts the sequence
//            from the seed, advance steps it once. The next value is also
//            exported so the caller can register it in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mac_bist_lfsr
    import mac_bist_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_seed,
    output logic [31:0] o_value,
    output logic [31:0] o_value_next
);

    logic [31:0] r_lfsr;

    // Sequence state: load takes priority over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= lfsr_fix_seed(RESET_SEED);
        end else if (i_load) begin
            r_lfsr <= lfsr_fix_seed(i_seed);
        end else if (i_advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value      = r_lfsr;
    assign o_value_next = lfsr_next(r_lfsr);

endmodule
`default_nettype wire

// File: rtl/mac_bist_driver.sv
`default_nettype none
// ============================================================================
// Module   : mac_bist_driver
// Brief    : On-chip stimulus generator and response checker for a pair of
//            MAC instances (golden and netlist). Runs a reset/settle phase,
//            drives NUM_VECTORS pseudo-random operand pairs, compares the two
//            outputs at the end of every hold and reports mismatch count,
//            compare count, first failing index and a pass flag.
// Revision : 1.0 - initial release
// ============================================================================
module mac_bist_driver
    import mac_bist_pkg::*;
#(
    parameter int          DATA_W        = 16,
    parameter int          OUT_W         = 32,
    parameter int          NUM_VECTORS   = 1000,
    parameter int          RESET_CYCLES  = 10,
    parameter int          SETTLE_CYCLES = 5,
    parameter int          HOLD_CYCLES   = 2,
    parameter int          DRAIN_CYCLES  = 10,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
)(
    input  logic              clock0,
    input  logic              reset,
    input  logic              start,
    input  logic [OUT_W-1:0]  golden_out,
    input  logic [OUT_W-1:0]  netlist_out,
    output logic              dut_reset,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  compare_count,
    output logic [CNT_W-1:0]  first_fail_idx
);

    // Phase counter must hold the longest of the four timed phases (all >= 1).
    localparam int c_max_rs = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int c_max_hd = (HOLD_CYCLES > DRAIN_CYCLES) ? HOLD_CYCLES : DRAIN_CYCLES;
    localparam int c_ph_max = (c_max_rs > c_max_hd) ? c_max_rs : c_max_hd;
    localparam int c_ph_w   = $clog2(c_ph_max + 1);
    localparam int c_vec_w  = $clog2(NUM_VECTORS + 1);

    localparam logic [c_ph_w-1:0]  c_rst_last    = c_ph_w'(RESET_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_settle_last = c_ph_w'(SETTLE_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_hold_last   = c_ph_w'(HOLD_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_drain_last  = c_ph_w'(DRAIN_CYCLES - 1);
    localparam logic [c_vec_w-1:0] c_vec_last    = c_vec_w'(NUM_VECTORS);
    localparam logic [CNT_W-1:0]   c_cnt_max     = {CNT_W{1'b1}};

    state_t             r_state;
    logic [c_ph_w-1:0]  r_phase;
    logic [c_vec_w-1:0] r_vec;

    logic               w_run_start;
    logic               w_settle_end;
    logic               w_hold_end;
    logic               w_cmp_en;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_cmp_idx;
    logic [31:0]        w_lfsr_q;
    logic [31:0]        w_lfsr_d;

    assign w_run_start  = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_settle_end = (r_state == SETTLE) && (r_phase == c_settle_last);
    assign w_hold_end   = (r_state == RUN) && (r_phase == c_hold_last);
    assign w_cmp_en     = w_settle_end || w_hold_end;
    assign w_mismatch   = (golden_out != netlist_out);
    // r_vec is still 0 during SETTLE, so it doubles as compare index 0.
    assign w_cmp_idx    = CNT_W'(r_vec);

    mac_bist_lfsr #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk          (clock0),
        .rst          (reset),
        .i_load       (w_run_start),
        .i_advance    (w_hold_end),
        .i_seed       (LFSR_SEED),
        .o_value      (w_lfsr_q),
        .o_value_next (w_lfsr_d)
    );

    // Run sequencer: phase timing, DUT reset/operand drive and status flags.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_vec     <= '0;
            dut_reset <= 1'b1;
            dut_a     <= '0;
            dut_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_run_start) begin
                        r_state   <= RST_HOLD;
                        r_phase   <= '0;
                        r_vec     <= '0;
                        dut_reset <= 1'b1;
                        dut_a     <= '0;
                        dut_b     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RST_HOLD: begin
                    if (r_phase == c_rst_last) begin
                        r_state   <= SETTLE;
                        r_phase   <= '0;
                        dut_reset <= 1'b0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                SETTLE: begin
                    if (w_settle_end) begin
                        r_state <= RUN;
                        r_phase <= '0;
                        r_vec   <= c_vec_w'(1);
                        dut_a   <= w_lfsr_q[31 -: DATA_W];
                        dut_b   <= w_lfsr_q[DATA_W-1:0];
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                RUN: begin
                    if (w_hold_end) begin
                        r_phase <= '0;
                        if (r_vec == c_vec_last) begin
                            // Last vector stays on the operands through DRAIN.
                            r_state <= DRAIN;
                        end else begin
                            r_vec <= r_vec + c_vec_w'(1);
                            dut_a <= w_lfsr_d[31 -: DATA_W];
                            dut_b <= w_lfsr_d[DATA_W-1:0];
                        end
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                DRAIN: begin
                    if (r_phase == c_drain_last) begin
                        r_state <= DONE;
                        r_phase <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // No compares happen in DRAIN, so the count is final here.
                        pass    <= (mismatch_count == '0);
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Response checker: saturating counters and first-failure capture.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            mismatch_count <= '0;
            compare_count  <= '0;
            first_fail_idx <= c_cnt_max;
        end else if (w_run_start) begin
            mismatch_count <= '0;
            compare_count  <= '0;
            first_fail_idx <= c_cnt_max;
        end else if (w_cmp_en) begin
            if (compare_count != c_cnt_max) begin
                compare_count <= compare_count + CNT_W'(1);
            end
            if (w_mismatch) begin
                // A zero count marks the first failure even if its index is all-ones.
                if (mismatch_count == '0) begin
                    first_fail_idx <= w_cmp_idx;
                end
                if (mismatch_count != c_cnt_max) begin
                    mismatch_count <= mismatch_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
